// File: rtl/hazard_scheduler.sv
// Sequencing controller for the 5-stage MIPS pipeline: tracks in-flight register
// writes, stalls on RAW/load-use hazards and flushes on jumps and taken branches.
module hazard_scheduler #(
   parameter bit FORWARDING = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } slot_t;

   logic             use_rs, use_rt, is_load, is_jump;
   logic [4:0]       dest;
   slot_t            ex_q, ex_d;
   logic             mem_valid_q;
   logic [4:0]       mem_dest_q;
   logic             ex_hit, mem_hit, hazard, stall, jump;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      is_load = 1'b0;
      is_jump = 1'b0;
      dest    = 5'd0;
      case (id_opcode)
         OP_RTYPE: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            dest   = id_rd;
         end
         OP_LW: begin
            use_rs  = 1'b1;
            dest    = id_rt;
            is_load = 1'b1;
         end
         OP_SW, OP_BEQ: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         OP_J:   is_jump = 1'b1;
         OP_JAL: begin
            is_jump = 1'b1;
            dest    = 5'd31;
         end
         OP_ADDI, OP_ORI: begin
            use_rs = 1'b1;
            dest   = id_rt;
         end
         default: ;
      endcase
   end

   // The WB write lands in the first half-cycle, so only EX and MEM need tracking.
   assign ex_hit  = ex_q.valid && (ex_q.dest != 5'd0) &&
                    ((use_rs && (ex_q.dest == id_rs)) || (use_rt && (ex_q.dest == id_rt)));
   assign mem_hit = mem_valid_q && (mem_dest_q != 5'd0) &&
                    ((use_rs && (mem_dest_q == id_rs)) || (use_rt && (mem_dest_q == id_rt)));
   assign hazard  = FORWARDING ? (ex_hit && ex_q.is_load) : (ex_hit || mem_hit);
   assign stall   = id_valid && hazard && !ex_branch_taken;
   assign jump    = id_valid && is_jump;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else if (jump) begin
         ifid_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      ex_d        = '{valid: id_valid, dest: dest, is_load: is_load};
      if (ex_branch_taken || stall) ex_d = '0;
      if (ex_branch_taken || (!stall && jump)) begin
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (stall) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all slots shift on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q        <= '0;
         mem_valid_q <= 1'b0;
         mem_dest_q  <= 5'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (!mem_busy) begin
         ex_q        <= ex_d;
         mem_valid_q <= ex_q.valid;
         mem_dest_q  <= ex_q.dest;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Keeps a 3-slot scoreboard of in-flight register writes for EX, MEM and WB, and checks each ID instruction's sources against it.
- Drives the PC and pipeline-register enable, flush and bubble signals.
- Handles load-use and RAW stalls, jump and taken-branch flushes, and data-memory freezes, and keeps stall and flush performance counters.

Parameters:
- FORWARDING, 1: 1 means the forwarding unit is present, so only load-use stalls are needed. 0 means no forwarding, so all RAW hazards against EX/MEM stall.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID register holds a real instruction.
- id_opcode  in  6  opcode of the ID instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_rd  in  5  rd field of the ID instruction.
- ex_branch_taken  in  1  beq in EX resolved as taken.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- exmem_en  out  1  EX/MEM write enable.
- memwb_en  out  1  MEM/WB write enable.
- stall_cnt  out  CNT_W  count of stall cycles.
- flush_cnt  out  CNT_W  count of flush events.

Behaviour:
- Decode, combinational on id_opcode.
  - 000000 (R-type): uses rs and rt; dest rd.
  - 100011 (lw): uses rs; dest rt; load.
  - 101011 (sw): uses rs and rt; no dest.
  - 000100 (beq): uses rs and rt; no dest.
  - 000010 (j): uses nothing; no dest; jump.
  - 000011 (jal): uses nothing; dest 31; jump.
  - 001000 (addi) and 001101 (ori): use rs; dest rt.
  - Any other opcode: uses nothing, no dest, treated as NOP.
- Scoreboard: slots EX, MEM, WB, each holding {valid, dest[4:0], is_load}. A slot with dest 0 never matches.
- hazard (FORWARDING=1): EX slot valid, is_load, dest!=0, and dest equals a used source.
- hazard (FORWARDING=0): EX or MEM slot valid, dest!=0, and dest equals a used source. WB does not hazard, because the register file writes in the first half-cycle.
- stall = id_valid & hazard & ~ex_branch_taken.
- Output priority (all outputs combinational from state and inputs; zero latency):
  1. mem_busy=1: pc_en, ifid_en, exmem_en and memwb_en are all 0; ifid_flush and idex_bubble are 0; scoreboard holds; counters hold. This overrides everything, including a taken branch, which must be held by the EX stage until mem_busy drops.
  2. ex_branch_taken=1: ifid_flush=1, idex_bubble=1; pc_en, ifid_en, exmem_en and memwb_en are 1. Counts as one flush.
  3. stall=1: pc_en=0, ifid_en=0, idex_bubble=1; exmem_en and memwb_en are 1; ifid_flush=0. Counts as one stall cycle.
  4. Jump in ID (id_valid, opcode j or jal): ifid_flush=1; all enables 1; idex_bubble=0. Counts as one flush.
  5. Otherwise: all enables 1; ifid_flush and idex_bubble are 0.
- Scoreboard update on the rising edge when mem_busy=0:
  - WB <= MEM, and MEM <= EX.
  - EX <= ID instruction {id_valid, dest, is_load} when idex_bubble=0.
  - EX <= invalid when idex_bubble=1.
- A load-use stall lasts exactly 1 cycle with FORWARDING=1. With FORWARDING=0 a stall lasts up to 2 cycles.
- Counters saturate at 2^CNT_W-1 with no wrap. stall_cnt and flush_cnt can both increment in the same cycle only if different rules fire; given the priority above, at most one increments per cycle.
- Reset (asynchronous, active-high):
  - All slots invalid; counters 0.
  - While reset=1: pc_en, ifid_en, exmem_en and memwb_en are 0; ifid_flush and idex_bubble are 1.
  - Release takes effect cleanly on the next edge.
  - Reset mid-stall discards the scoreboard. There is no residual stall after release.

Test Plan:
- FORWARDING=1: lw $2 then add $3,$2,$4 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1; add proceeds on the next cycle.
- FORWARDING=0: add $5,$1,$1 then sub $6,$5,$1 -> 2 stall cycles, then the cycle after that has no stall; stall_cnt=2.
- Writes to $0 (addi $0,$1,5 then add $3,$0,$0), both FORWARDING values -> no stall.
- Taken branch coinciding with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt unchanged; flush_cnt+1.
- jal in ID -> ifid_flush=1 for one cycle; EX slot gets dest 31 on the next edge.
- Following add $4,$31,$0 -> no stall with FORWARDING=1.
- mem_busy held 3 cycles during a pending load-use hazard -> all enables 0 and counters frozen. After release, the 1-cycle stall occurs.
- Counter saturation: CNT_W=2 with 5 stalls -> stall_cnt=3.
- Async reset asserted mid-stall -> outputs take reset values immediately with no clock edge.
